// File: rtl/kbd_cmd_queue.sv
// Keyboard command queue: maps released-key scan codes to 4-bit
// commands, tracks the edit mode and buffers commands in a show-ahead FIFO.
// Ports: clk, reset (async, active-high), key_code/key_valid (scan code in),
//   cmd_rd (pop), clr_ovf (clear overflow), cmd/cmd_valid (queue head),
//   count (entries queued), mode (edit mode), ovf (sticky drop flag).
module kbd_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_code,
  input  logic          key_valid,
  input  logic          cmd_rd,
  input  logic          clr_ovf,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  output logic [AW:0]   count,
  output logic [1:0]    mode,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_FECHA = 2'd1,
    EDIT_HORA  = 2'd2,
    EDIT_TIMER = 2'd3
  } mode_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  mode_t         state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [3:0] code;
  mode_t      sel_mode;
  logic       is_sel;
  logic       is_arrow;
  logic       is_esc;

  always_comb begin
    code     = 4'h0;
    sel_mode = IDLE;
    is_sel   = 1'b0;
    is_arrow = 1'b0;
    is_esc   = 1'b0;
    case (key_code)
      8'h2B: begin code = 4'h1; is_sel = 1'b1; sel_mode = EDIT_FECHA; end
      8'h33: begin code = 4'h2; is_sel = 1'b1; sel_mode = EDIT_HORA; end
      8'h2C: begin code = 4'h3; is_sel = 1'b1; sel_mode = EDIT_TIMER; end
      8'h75: begin code = 4'h4; is_arrow = 1'b1; end
      8'h74: begin code = 4'h5; is_arrow = 1'b1; end
      8'h6B: begin code = 4'h6; is_arrow = 1'b1; end
      8'h72: begin code = 4'h7; is_arrow = 1'b1; end
      8'h76: begin code = 4'h8; is_esc = 1'b1; end
      default: ;
    endcase
  end

  logic empty, full, esc, push, pop, wr_ok, drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign esc   = key_valid && is_esc;
  // Mode keys only count in IDLE, arrows only while editing.
  assign push  = key_valid &&
                 ((is_sel && state == IDLE) ||
                  (is_arrow && state != IDLE));
  assign pop   = cmd_rd && !empty;
  // A pop in the same cycle frees the slot a full queue needs.
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign cmd       = empty ? 4'h0 : mem[rd_ptr];
  assign cmd_valid = !empty;
  assign mode      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      ovf    <= 1'b0;
    end else begin
      if (esc) begin
        // Flush: ESC becomes the only entry, any pop is discarded.
        mem[0] <= 4'h8;
        rd_ptr <= '0;
        wr_ptr <= AW'(1);
        count  <= (AW+1)'(1);
        state  <= IDLE;
      end else begin
        if (wr_ok) begin
          mem[wr_ptr] <= code;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (wr_ok && !pop)
          count <= count + 1'b1;
        else if (!wr_ok && pop)
          count <= count - 1'b1;
        // Mode still moves even if the command itself was dropped.
        if (push && state == IDLE) state <= sel_mode;
      end
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule
